inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Receiving end of the IF1→FIFO packet handshake: accepts the fetch packets produced by the IF1 stage and presents them in order to the decode stage.
- Each packet is one fetch group: pc, pc_next, two-bit taken flags, inst0, inst1, icache badv, exception code and exception flags.
- Generates the backpressure signals (fifo_allowin, space_ok, nearly_full) that the IF1 stage uses to throttle icache requests.

Parameters:
- DEPTH, 8, number of packet entries; power of two, minimum 4.
- LOG_DEPTH, 3, log2(DEPTH).

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous queue clear from backend redirect.
- fifo_readygo  input  1  IF1 packet valid.
- fifo_allowin  output  1  queue can accept a packet this cycle.
- space_ok  output  1  at least 3 free entries.
- nearly_full  output  1  exactly 1 or 2 free entries.
- in_pc  input  32  packet pc.
- in_pc_next  input  32  predicted next pc.
- in_pc_taken  input  2  per-slot taken flags.
- in_inst0  input  32  slot-0 instruction.
- in_inst1  input  32  slot-1 instruction (NOP when in_pc[2]=1).
- in_badv  input  32  icache bad virtual address.
- in_exception  input  7  icache exception code.
- in_excp_flag  input  2  per-slot exception flags.
- id_valid  output  1  head packet valid.
- id_ready  input  1  decode consumes head packet.
- id_pc, id_pc_next, id_inst0, id_inst1, id_badv  output  32 each  head packet fields.
- id_pc_taken  output  2  head packet taken flags.
- id_exception  output  7  head packet exception code.
- id_excp_flag  output  2  head packet exception flags.
- id_inst1_valid  output  1  slot 1 holds a real instruction (!id_pc[2]).
- count  output  LOG_DEPTH+1  occupancy, for debug and perf counters.

Behaviour:
- Storage: DEPTH-entry circular buffer, 171-bit entries.
- Pointers: wr_ptr and rd_ptr, LOG_DEPTH bits each, wrap modulo DEPTH. Occupancy is held in a count register (0..DEPTH).
- Reset (async): wr_ptr=0, rd_ptr=0, count=0. Storage contents are don't-care.
- push = fifo_readygo && fifo_allowin.
  - Write entry at wr_ptr, then wr_ptr+1.
  - The packet is visible on id_* the next cycle at the earliest. There is no same-cycle bypass.
- pop = id_valid && id_ready. rd_ptr+1.
- Count update:
  - push and not pop: count+1.
  - pop and not push: count−1.
  - both: unchanged.
- fifo_allowin = (count != DEPTH).
  - Depends only on registered state; no combinational path from id_ready.
  - When full, a same-cycle pop does NOT admit a push.
- space_ok = (DEPTH−count) >= 3.
- nearly_full = (DEPTH−count) is 1 or 2.
- Full state: space_ok=0, nearly_full=0, fifo_allowin=0.
- Head presentation:
  - id_valid = (count != 0).
  - id_* fields are driven combinationally from the entry at rd_ptr (show-ahead).
- Empty state:
  - id_valid=0.
  - id_inst0 = id_inst1 = `INST_NOP.
  - All other id_* fields = 0. id_inst1_valid=0.
- Head stability: the head entry and its fields stay unchanged while id_valid=1 and id_ready=0.
- Flush:
  - Synchronous, highest priority.
  - Next cycle: wr_ptr=0, rd_ptr=0, count=0.
  - A push or pop in the flush cycle is discarded and does not write storage.
  - fifo_allowin is not gated by flush in the flush cycle. IF1 treats a packet handed over during flush as dropped.
- Reset mid-operation: asynchronously returns to empty. All outputs take the empty values listed above.
- No state machine beyond the pointer/count registers. Pointer wrap is natural modulo arithmetic.
- Assertions: count never exceeds DEPTH; no pop when empty.

Test Plan:
- Reset then 3 pushes (pc=0x1c000000, 0x1c000008, 0x1c000010), id_ready=0 → count=3, id_valid=1, id_pc=0x1c000000 held. Raise id_ready for 3 cycles → pcs emerge in order, then id_valid=0 and id_inst0=`INST_NOP.
- Push 8 packets with id_ready=0 (DEPTH=8) →
  - count=5: space_ok=1.
  - count=6: space_ok=0, nearly_full=1.
  - count=8: fifo_allowin=0, nearly_full=0.
  - A 9th fifo_readygo with id_ready=1 → pop only, count=7, 9th packet not written.
- Continuous push and pop for 20 cycles from count=2 → count stays 2; pointers wrap past 7; output pc sequence strictly in push order.
- Flush asserted with count=5 while fifo_readygo=1 and id_ready=1 → next cycle count=0, id_valid=0; the pushed packet never appears at id_*.
- Push packet with in_pc=0x1c000004, inst1=`INST_NOP, excp_flag=2'b01 → id_inst1_valid=0, id_excp_flag=2'b01, fields match.
- Assert rstn=0 asynchronously mid-stream with count=4 → id_valid=0 immediately (before the clock edge), count=0; after release, first push appears one cycle later.

Source files
------------

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue -- in-order packet queue between the IF1 stage and decode.
//
// IF1 hands over one fetch group per cycle (fifo_readygo && fifo_allowin).
// Decode sees the oldest packet on id_*. The outputs are show-ahead:
// id_* are driven combinationally from the head entry, and decode
// consumes the head with id_valid && id_ready.
// fifo_allowin, space_ok and nearly_full come only from the count
// register. IF1 uses them to throttle icache requests.
//
// Ports:
//   clk, rstn          clock; asynchronous active-low reset
//   flush              synchronous clear (backend redirect), highest priority
//   fifo_readygo       IF1 packet valid
//   fifo_allowin       queue not full
//   space_ok           >= 3 free entries
//   nearly_full        exactly 1 or 2 free entries
//   in_*               incoming packet fields
//   id_valid/id_ready  head handshake toward decode
//   id_*               head packet fields (NOP/zero when empty)
//   id_inst1_valid     slot 1 carries a real instruction (!id_pc[2])
//   count              occupancy 0..DEPTH
// ----------------------------------------------------------------------------
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module inst_queue #(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 fifo_readygo,
    output logic                 fifo_allowin,
    output logic                 space_ok,
    output logic                 nearly_full,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_pc_next,
    input  logic [1:0]           in_pc_taken,
    input  logic [31:0]          in_inst0,
    input  logic [31:0]          in_inst1,
    input  logic [31:0]          in_badv,
    input  logic [6:0]           in_exception,
    input  logic [1:0]           in_excp_flag,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc_next,
    output logic [1:0]           id_pc_taken,
    output logic [31:0]          id_inst0,
    output logic [31:0]          id_inst1,
    output logic [31:0]          id_badv,
    output logic [6:0]           id_exception,
    output logic [1:0]           id_excp_flag,
    output logic                 id_inst1_valid,
    output logic [LOG_DEPTH:0]   count
);

    // One fetch group is 171 bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [1:0]  pc_taken;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
    } entry_t;

    localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] ONE  = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH:0] TWO  = (LOG_DEPTH+1)'(2);
    localparam logic [LOG_DEPTH:0] THREE = (LOG_DEPTH+1)'(3);

    entry_t                 mem [DEPTH];
    entry_t                 wdata;
    entry_t                 head;
    logic [LOG_DEPTH-1:0]   wr_ptr, rd_ptr;
    logic [LOG_DEPTH:0]     free;
    logic                   push, pop;

    assign free         = FULL - count;
    // Registered state only. A pop in a full cycle does not admit a push,
    // so there is no combinational path from id_ready to IF1.
    assign fifo_allowin = (count != FULL);
    assign space_ok     = (free >= THREE);
    assign nearly_full  = (free == ONE) || (free == TWO);

    assign id_valid = (count != '0);
    assign push     = fifo_readygo && fifo_allowin;
    assign pop      = id_valid && id_ready;

    assign wdata = '{pc: in_pc, pc_next: in_pc_next, pc_taken: in_pc_taken,
                     inst0: in_inst0, inst1: in_inst1, badv: in_badv,
                     exception: in_exception, excp_flag: in_excp_flag};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage has no reset. Empty-state outputs are forced below.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        id_pc          = '0;
        id_pc_next     = '0;
        id_pc_taken    = '0;
        id_inst0       = `INST_NOP;
        id_inst1       = `INST_NOP;
        id_badv        = '0;
        id_exception   = '0;
        id_excp_flag   = '0;
        id_inst1_valid = 1'b0;
        if (id_valid) begin
            id_pc          = head.pc;
            id_pc_next     = head.pc_next;
            id_pc_taken    = head.pc_taken;
            id_inst0       = head.inst0;
            id_inst1       = head.inst1;
            id_badv        = head.badv;
            id_exception   = head.exception;
            id_excp_flag   = head.excp_flag;
            // A fetch group that starts at pc[2]=1 carries only one instruction.
            id_inst1_valid = !head.pc[2];
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (!rstn) count <= FULL);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn)
                                     !(pop && count == '0));

endmodule

// File: tb/tb_inst_queue.sv
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module tb_inst_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [1:0]  pc_taken;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
    } pkt_t;

    logic clk = 0, rstn = 0, flush = 0, fifo_readygo = 0, id_ready = 0;
    logic fifo_allowin, space_ok, nearly_full, id_valid, id_inst1_valid;
    pkt_t in;
    logic [31:0] id_pc, id_pc_next, id_inst0, id_inst1, id_badv;
    logic [1:0]  id_pc_taken, id_excp_flag;
    logic [6:0]  id_exception;
    logic [3:0]  count;

    int checks = 0, failures = 0;
    pkt_t sb[$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(8), .LOG_DEPTH(3)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .fifo_readygo(fifo_readygo),
        .fifo_allowin(fifo_allowin), .space_ok(space_ok), .nearly_full(nearly_full),
        .in_pc(in.pc), .in_pc_next(in.pc_next), .in_pc_taken(in.pc_taken),
        .in_inst0(in.inst0), .in_inst1(in.inst1), .in_badv(in.badv),
        .in_exception(in.exception), .in_excp_flag(in.excp_flag),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_pc_next(id_pc_next), .id_pc_taken(id_pc_taken),
        .id_inst0(id_inst0), .id_inst1(id_inst1), .id_badv(id_badv),
        .id_exception(id_exception), .id_excp_flag(id_excp_flag),
        .id_inst1_valid(id_inst1_valid), .count(count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic pkt_t mk(input logic [31:0] pc);
        pkt_t p;
        p.pc        = pc;
        p.pc_next   = pc + 32'd8;
        p.pc_taken  = pc[4:3];
        p.inst0     = {pc[15:0], 16'h0a01};
        p.inst1     = pc[2] ? `INST_NOP : {pc[15:0], 16'h0b02};
        p.badv      = pc ^ 32'h0000_ffff;
        p.exception = 7'(pc[9:3]);
        p.excp_flag = 2'b00;
        return p;
    endfunction

    // Scoreboard monitor: compare head against the oldest expected packet
    // whenever the DUT presents one; retire it on a non-flushed handshake.
    always @(negedge clk) begin
        if (rstn && id_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_head", id_pc, 32'hxxxx_xxxx);
            end else begin
                chk("id_pc",        id_pc,               sb[0].pc);
                chk("id_pc_next",   id_pc_next,          sb[0].pc_next);
                chk("id_pc_taken",  32'(id_pc_taken),    32'(sb[0].pc_taken));
                chk("id_inst0",     id_inst0,            sb[0].inst0);
                chk("id_inst1",     id_inst1,            sb[0].inst1);
                chk("id_badv",      id_badv,             sb[0].badv);
                chk("id_exception", 32'(id_exception),   32'(sb[0].exception));
                chk("id_excp_flag", 32'(id_excp_flag),   32'(sb[0].excp_flag));
                chk("id_inst1_valid", 32'(id_inst1_valid), 32'(!sb[0].pc[2]));
                if (id_ready && !flush) void'(sb.pop_front());
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge. acc marks a
    // packet the queue is expected to take at the next edge.
    task automatic step(input bit rg, input pkt_t p, input bit rdy, input bit fl, input bit acc);
        @(posedge clk); #1;
        fifo_readygo = rg; in = p; id_ready = rdy; flush = fl;
        if (acc) sb.push_back(p);
    endtask

    task automatic idle(input bit rdy);
        step(0, '0, rdy, 0, 0);
    endtask

    task automatic chk_empty(input string nm);
        chk({nm, "_valid"}, 32'(id_valid), 0);
        chk({nm, "_count"}, 32'(count), 0);
        chk({nm, "_inst0"}, id_inst0, `INST_NOP);
        chk({nm, "_inst1"}, id_inst1, `INST_NOP);
        chk({nm, "_pc"},    id_pc, 0);
        chk({nm, "_i1v"},   32'(id_inst1_valid), 0);
    endtask

    initial begin
        pkt_t p;
        in = '0;
        repeat (3) @(posedge clk);
        #1; chk_empty("reset");
        chk("reset_allowin", 32'(fifo_allowin), 1);
        chk("reset_space_ok", 32'(space_ok), 1);
        chk("reset_nearly_full", 32'(nearly_full), 0);
        rstn = 1;

        // 1: three pushes held, then drained in order
        for (int i = 0; i < 3; i++) step(1, mk(32'h1c000000 + 32'(i*8)), 0, 0, 1);
        idle(0);
        chk("t1_count", 32'(count), 3);
        chk("t1_valid", 32'(id_valid), 1);
        chk("t1_pc", id_pc, 32'h1c000000);
        idle(0);
        chk("t1_pc_held", id_pc, 32'h1c000000);
        repeat (3) idle(1);
        idle(0);
        chk_empty("t1_drained");

        // 2: fill to DEPTH and watch the backpressure flags
        for (int i = 0; i < 8; i++) begin
            step(1, mk(32'h1c001000 + 32'(i*8)), 0, 0, 1);
            chk("t2_count", 32'(count), 32'(i));
            if (i == 5) begin
                chk("t2_c5_space_ok", 32'(space_ok), 1);
                chk("t2_c5_nearly_full", 32'(nearly_full), 0);
            end
            if (i == 6) begin
                chk("t2_c6_space_ok", 32'(space_ok), 0);
                chk("t2_c6_nearly_full", 32'(nearly_full), 1);
            end
        end
        idle(0);
        chk("t2_full_count", 32'(count), 8);
        chk("t2_full_allowin", 32'(fifo_allowin), 0);
        chk("t2_full_nearly_full", 32'(nearly_full), 0);
        chk("t2_full_space_ok", 32'(space_ok), 0);
        step(1, mk(32'h1c00dead), 1, 0, 0);   // pop only; this packet is refused
        idle(0);
        chk("t2_after9_count", 32'(count), 7);
        repeat (7) idle(1);
        idle(0);
        chk("t2_drained_count", 32'(count), 0);

        // 3: steady push+pop from count=2, pointers wrap
        for (int i = 0; i < 2; i++) step(1, mk(32'h1c002000 + 32'(i*8)), 0, 0, 1);
        for (int i = 2; i < 22; i++) begin
            step(1, mk(32'h1c002000 + 32'(i*8)), 1, 0, 1);
            chk("t3_count", 32'(count), 2);
        end
        idle(1); idle(1); idle(0);
        chk("t3_drained_count", 32'(count), 0);

        // 4: flush at count=5 with a push and pop in the same cycle
        for (int i = 0; i < 5; i++) step(1, mk(32'h1c003000 + 32'(i*8)), 0, 0, 1);
        idle(0);
        chk("t4_count", 32'(count), 5);
        step(1, mk(32'h1c00beef), 1, 1, 0);
        idle(0);
        sb.delete();
        chk_empty("t4_flushed");
        idle(0);
        chk("t4_still_empty", 32'(id_valid), 0);

        // 5: single-instruction group with exception flag on slot 0
        p = mk(32'h1c000004);
        p.excp_flag = 2'b01;
        p.exception = 7'h08;
        step(1, p, 0, 0, 1);
        idle(0);
        chk("t5_inst1_valid", 32'(id_inst1_valid), 0);
        chk("t5_excp_flag", 32'(id_excp_flag), 32'b01);
        chk("t5_inst1", id_inst1, `INST_NOP);
        idle(1);
        idle(0);

        // 6: asynchronous reset mid-stream with count=4
        for (int i = 0; i < 4; i++) step(1, mk(32'h1c004000 + 32'(i*8)), 0, 0, 1);
        idle(0);
        chk("t6_count", 32'(count), 4);
        #2 rstn = 0;
        #1 chk_empty("t6_async_reset");
        sb.delete();
        @(posedge clk); #1 rstn = 1;
        step(1, mk(32'h1c005000), 0, 0, 1);
        chk("t6_no_bypass", 32'(id_valid), 0);
        idle(0);
        chk("t6_first_valid", 32'(id_valid), 1);
        chk("t6_first_pc", id_pc, 32'h1c005000);
        idle(1);
        idle(0);
        chk("t6_end_count", 32'(count), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
